// File: rtl/mult_seq_ctrl_if.sv
// Handshake bundle between the execute stage and the multi-cycle MUL unit.
// The master side issues start/a/b; the slave side reports busy/done/product.
interface mult_seq_ctrl_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequential 16x16 -> 32-bit unsigned shift-add multiplier built on one 16-bit CLA.
// Optional macro MULT_ZERO_SKIP_EN: a zero operand completes in one cycle without iterating.

module cla_adder16 (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] Sum,
    output logic        Cout
);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    assign g = A & B;
    assign p = A ^ B;

    // Two-level lookahead: 4-bit groups feed a group-level carry unit.
    for (genvar k = 0; k < 4; k++) begin : grp
        logic [3:0] gk;
        logic [3:0] pk;

        assign gk = g[4*k +: 4];
        assign pk = p[4*k +: 4];

        assign gg[k] = gk[3]
                     | (pk[3] & gk[2])
                     | (pk[3] & pk[2] & gk[1])
                     | (pk[3] & pk[2] & pk[1] & gk[0]);
        assign gp[k] = &pk;

        assign c[4*k]   = gc[k];
        assign c[4*k+1] = gk[0] | (pk[0] & gc[k]);
        assign c[4*k+2] = gk[1] | (pk[1] & gk[0]) | (pk[1] & pk[0] & gc[k]);
        assign c[4*k+3] = gk[2] | (pk[2] & gk[1]) | (pk[2] & pk[1] & gk[0])
                        | (pk[2] & pk[1] & pk[0] & gc[k]);
    end

    assign gc[0] = Cin;
    assign gc[1] = gg[0] | (gp[0] & Cin);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & Cin);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & Cin);
    assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & Cin);

    assign Sum  = p ^ c;
    assign Cout = gc[4];
endmodule

module mult_seq_ctrl (
    input  logic           clk,
    input  logic           rst,
    mult_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] mcand;
    logic [15:0] hi;
    logic [15:0] lo;
    logic [3:0]  cnt;

    logic [15:0] add_b;
    logic [15:0] add_sum;
    logic        add_cout;
    logic        accept;
    logic        skip;

    assign add_b = lo[0] ? mcand : 16'h0000;

    cla_adder16 u_adder (
        .A    (hi),
        .B    (add_b),
        .Cin  (1'b0),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    assign accept = bus.start && ((state == IDLE) || (state == DONE));

`ifdef MULT_ZERO_SKIP_EN
    assign skip = (bus.a == 16'h0000) || (bus.b == 16'h0000);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = skip ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == 4'd15) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_nxt = skip ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The carry-out lands in hi[15] so a full FFFF*FFFF stays exact.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= 16'h0000;
            hi    <= 16'h0000;
            lo    <= 16'h0000;
            cnt   <= 4'd0;
        end else if (accept) begin
            mcand <= bus.a;
            hi    <= 16'h0000;
            lo    <= skip ? 16'h0000 : bus.b;
            cnt   <= 4'd0;
        end else if (state == RUN) begin
            {hi, lo} <= {add_cout, add_sum, lo[15:1]};
            cnt      <= cnt + 4'd1;
        end
    end

    assign bus.busy    = (state == RUN);
    assign bus.done    = (state == DONE);
    assign bus.product = {hi, lo};
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed cases with literal results plus
// a randomized run checked every cycle against a latency/arithmetic model.
module tb_mult_seq_ctrl;
    logic clk;
    logic rst;
    int   cyc;
    int   nChecks;
    int   nFails;

`ifdef MULT_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    mult_seq_ctrl_if bus ();

    mult_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: remaining busy cycles, pending done, and the expected product.
    int          mRunLeft;
    bit          mDone;
    bit          mValid;
    bit          mOn;
    logic [31:0] mExp;

    always @(posedge clk) begin
        if (rst) begin
            mRunLeft = 0;
            mDone    = 1'b0;
            mValid   = 1'b1;
            mExp     = 32'h0;
            mOn      = 1'b1;
        end else if (mOn) begin
            if (mRunLeft > 0) begin
                mRunLeft = mRunLeft - 1;
                mDone    = (mRunLeft == 0);
                if (mDone) mValid = 1'b1;
            end else if (bus.start) begin
                mExp   = 32'(bus.a) * 32'(bus.b);
                mValid = 1'b0;
                if (SKIP && (bus.a == 16'h0 || bus.b == 16'h0)) begin
                    mDone  = 1'b1;
                    mValid = 1'b1;
                end else begin
                    mRunLeft = 16;
                    mDone    = 1'b0;
                end
            end else begin
                mDone = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mOn && !rst) begin
            checkOutput("model_busy", 32'(bus.busy), 32'(mRunLeft > 0));
            checkOutput("model_done", 32'(bus.done), 32'(mDone));
            if (mValid) checkOutput("model_product", bus.product, mExp);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    int t0;

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        t0        = cyc;
        step();
        bus.start = 1'b0;
    endtask

    task automatic waitDone(input string name, output int lat, output int nBusy);
        nBusy = 0;
        while (!bus.done && (cyc - t0) < 40) begin
            if (bus.busy) nBusy++;
            step();
        end
        lat = cyc - t0;
        if (!bus.done) checkOutput({name, "_timeout"}, 32'(lat), 32'd17);
    endtask

    int lat;
    int nBusy;
    int expLat;

    initial begin
        cyc       = 0;
        nChecks   = 0;
        nFails    = 0;
        mOn       = 1'b0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 16'h0;
        bus.b     = 16'h0;
        step();
        step();
        rst = 1'b0;
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_product", bus.product, 32'h0);

        applyStimulus(16'h0003, 16'h0005);
        waitDone("basic", lat, nBusy);
        checkOutput("basic_latency", 32'(lat), 32'd17);
        checkOutput("basic_busy_cycles", 32'(nBusy), 32'd16);
        checkOutput("basic_product", bus.product, 32'h0000000F);
        step();
        checkOutput("basic_done_pulse", 32'(bus.done), 32'd0);
        step();
        step();
        checkOutput("basic_hold", bus.product, 32'h0000000F);

        applyStimulus(16'hFFFF, 16'hFFFF);
        waitDone("max", lat, nBusy);
        checkOutput("max_product", bus.product, 32'hFFFE0001);
        step();

        applyStimulus(16'h8000, 16'h0002);
        waitDone("shift", lat, nBusy);
        checkOutput("shift_product", bus.product, 32'h00010000);
        step();

        applyStimulus(16'h1234, 16'h0010);
        repeat (4) step();
        bus.a     = 16'h0001;
        bus.b     = 16'h0001;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.a     = 16'h5555;
        bus.b     = 16'hAAAA;
        waitDone("busy_start", lat, nBusy);
        checkOutput("busy_start_latency", 32'(lat), 32'd17);
        checkOutput("busy_start_product", bus.product, 32'h00012340);
        step();

        applyStimulus(16'h00FF, 16'h00FF);
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
        checkOutput("midrst_done", 32'(bus.done), 32'd0);
        checkOutput("midrst_product", bus.product, 32'h0);
        applyStimulus(16'h0002, 16'h0003);
        waitDone("after_rst", lat, nBusy);
        checkOutput("after_rst_latency", 32'(lat), 32'd17);
        checkOutput("after_rst_product", bus.product, 32'h00000006);
        step();

        applyStimulus(16'h0011, 16'h0022);
        waitDone("b2b_first", lat, nBusy);
        checkOutput("b2b_first_product", bus.product, 32'h00000242);
        applyStimulus(16'h0007, 16'h0009);
        checkOutput("b2b_busy_again", 32'(bus.busy), 32'd1);
        waitDone("b2b_second", lat, nBusy);
        checkOutput("b2b_spacing", 32'(lat), 32'd17);
        checkOutput("b2b_product", bus.product, 32'h0000003F);
        step();

        expLat = SKIP ? 1 : 17;
        applyStimulus(16'h0000, 16'hABCD);
        waitDone("zero", lat, nBusy);
        checkOutput("zero_latency", 32'(lat), 32'(expLat));
        checkOutput("zero_busy_cycles", 32'(nBusy), SKIP ? 32'd0 : 32'd16);
        checkOutput("zero_product", bus.product, 32'h0);
        step();

        // Random traffic: starts land in any state, occasional resets and zero operands.
        for (int i = 0; i < 1500; i++) begin
            bus.start = ($urandom_range(0, 3) == 0);
            bus.a     = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            bus.b     = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            rst       = ($urandom_range(0, 199) == 0);
            step();
        end
        bus.start = 1'b0;
        rst       = 1'b0;
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Sequential 16x16 -> 32-bit unsigned shift-add multiplier.
- Built around a single instance of the team's 16-bit carry-lookahead adder. Adder interface: inputs A[15:0], B[15:0], Cin; outputs Sum[15:0], Cout.
- The block owns the operand and accumulator registers, the iteration counter and the start/busy/done handshake.
- Sits beside the execute-stage ALU as the multi-cycle MUL unit. The pipeline stalls while busy is high.

Parameters:
- None. Width is fixed at 16 by the shared adder. Iteration count is fixed at 16.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE or DONE
- a  input  16  multiplicand; captured on accepted start
- b  input  16  multiplier; captured on accepted start
- busy  output  1  high while iterating (RUN state)
- done  output  1  one-cycle pulse: product valid
- product  output  32  result; held stable from done until the next accepted start

Behaviour:
- Registers:
  - mcand[15:0]
  - hi[15:0], the accumulator upper half
  - lo[15:0], which holds the unconsumed multiplier bits and collects the product low half
  - cnt[3:0]
  - state: IDLE, RUN, DONE
- Reset (rst=1 at an edge): state=IDLE, hi=lo=mcand=0, cnt=0. Outputs busy=0, done=0, product=0. Reset overrides any in-flight operation; the partial result is discarded.
- Adder hookup, combinational:
  - A=hi
  - B = lo[0] ? mcand : 16'h0000
  - Cin=0
- IDLE:
  - start=1: mcand<=a, lo<=b, hi<=0, cnt<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, one iteration per edge:
  - {hi,lo} <= {Cout, Sum[15:0], lo[15:1]}
  - cnt<=cnt+1
  - When cnt==15 at the edge, go to DONE.
  - start is ignored in RUN. Operands a and b are not re-sampled.
- DONE:
  - done=1 for exactly one cycle.
  - start=1 in DONE is accepted: same load as in IDLE, go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- Timing, with start high in cycle 0 from IDLE:
  - busy=1 in cycles 1..16.
  - done=1 in cycle 17.
  - Latency is 17 cycles; throughput is one multiply per 17 cycles with back-to-back starts.
- product = {hi,lo}. It is combinationally visible at all times but guaranteed only from the done cycle until the next accepted start.
- busy and done are never high in the same cycle. busy is decoded from the RUN state; done is decoded from the DONE state.
- Arithmetic:
  - Unsigned only; no overflow is possible (32-bit result).
  - The adder carry-out is always captured into hi[15], so FFFF*FFFF is exact.
- Boundary cases:
  - Operand changes on a or b after acceptance have no effect.
  - The cnt wrap from 15 to 0 coincides with the RUN->DONE transition.

Optional Feature:
- Macro: MULT_ZERO_SKIP_EN.
- Defined:
  - On an accepted start with a==0 or b==0, go directly to DONE with hi<=0, lo<=0. busy never asserts.
  - done=1 in cycle 1, i.e. latency 1.
  - Non-zero operands behave exactly as without the macro.
- Undefined: all operands take the full 16-iteration RUN sequence, with done in cycle 17.

Test Plan:
- Basic multiply:
  - Stimulus: a=0x0003, b=0x0005, start pulse in cycle 0.
  - Required: busy=1 in cycles 1-16, done=1 only in cycle 17, product=0x0000000F held until the next start.
- Carry/maximum:
  - Stimulus: a=0xFFFF, b=0xFFFF.
  - Required: product=0xFFFE0001 at done.
  - Stimulus: a=0x8000, b=0x0002.
  - Required: product=0x00010000.
- Start while busy:
  - Stimulus: a=0x1234, b=0x0010. In cycle 5 assert start with a=0x0001, b=0x0001.
  - Required: the second start is ignored; product=0x00012340 in cycle 17.
- Reset mid-operation:
  - Stimulus: rst=1 in cycle 8 of a 0x00FF*0x00FF operation.
  - Required: next cycle busy=0, done=0, product=0, state IDLE.
  - Then a new start with a=0x0002, b=0x0003 gives product=0x00000006 after 17 cycles.
- Back-to-back:
  - Stimulus: start held in the done cycle with a=0x0007, b=0x0009.
  - Required: busy reasserts the next cycle; the second done comes 17 cycles after the first with product=0x0000003F.
- Zero operand:
  - Stimulus: a=0x0000, b=0xABCD.
  - Required without MULT_ZERO_SKIP_EN: done in cycle 17, product=0.
  - Required with the macro: done in cycle 1, busy never high, product=0.
